// File: rtl/control_alarma_temp.sv
// Temperature alarm controller: paces sensor requests, waits for the answer
// with a timeout, and debounces out-of-range readings into cold/heat alarms.
module control_alarma_temp #(
  parameter int                 PERIODO      = 1000,
  parameter int                 TIMEOUT      = 64,
  parameter logic signed [10:0] TEMP_BAJO    = 11'sd180,
  parameter logic signed [10:0] TEMP_ALTO    = 11'sd259,
  parameter int                 N_ACTIVAR    = 3,
  parameter int                 N_DESACTIVAR = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               habilitar,
  input  logic signed [10:0] temp_in,
  input  logic               dato_valido,
  output logic               solicitud,
  output logic signed [10:0] temp_actual,
  output logic               muestra_nueva,
  output logic               alarma,
  output logic               alarma_frio,
  output logic               alarma_calor,
  output logic               error_sensor,
  output logic [1:0]         o_dbg_estado_seq,
  output logic [1:0]         o_dbg_estado_alarma
);

  // Handshake: solicitud is held high from the request until a cycle with
  // dato_valido=1 (reading taken on that edge) or until the timeout expires;
  // dato_valido outside that window carries no meaning.

  localparam int W_PER = (PERIODO > 2)      ? $clog2(PERIODO)          : 1;
  localparam int W_TO  = (TIMEOUT > 1)      ? $clog2(TIMEOUT)          : 1;
  localparam int W_NA  = (N_ACTIVAR > 1)    ? $clog2(N_ACTIVAR + 1)    : 1;
  localparam int W_ND  = (N_DESACTIVAR > 1) ? $clog2(N_DESACTIVAR + 1) : 1;

  localparam logic [W_PER-1:0] PER_MAX = W_PER'(PERIODO - 1);
  localparam logic [W_TO-1:0]  TO_MAX  = W_TO'(TIMEOUT - 1);
  localparam logic [W_NA-1:0]  NA_M1   = W_NA'(N_ACTIVAR - 1);
  localparam logic [W_ND-1:0]  ND_M1   = W_ND'(N_DESACTIVAR - 1);

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    SOLICITA = 2'd1
  } seq_t;

  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    PRE_ALARMA = 2'd1,
    ALARMA     = 2'd2,
    PRE_NORMAL = 2'd3
  } alm_t;

  // Single-flop release synchroniser: assertion is immediate, release lands
  // on a clock edge so the rest of the logic leaves reset cleanly.
  logic r_rst_sync;
  logic w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 1'b0;
    else        r_rst_sync <= 1'b1;
  end

  assign w_rst_n = r_rst_sync;

  seq_t             r_seq, w_seq_next;
  logic [W_PER-1:0] r_cnt_per, w_cnt_per_next;
  logic [W_TO-1:0]  r_cnt_to, w_cnt_to_next;
  logic             r_solicitud;
  logic             w_acepta;
  logic             w_expira;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_seq       <= ESPERA;
      r_cnt_per   <= '0;
      r_cnt_to    <= '0;
      r_solicitud <= 1'b0;
    end else begin
      r_seq       <= w_seq_next;
      r_cnt_per   <= w_cnt_per_next;
      r_cnt_to    <= w_cnt_to_next;
      r_solicitud <= (w_seq_next == SOLICITA);
    end
  end

  always_comb begin
    w_seq_next     = r_seq;
    w_cnt_per_next = r_cnt_per;
    w_cnt_to_next  = r_cnt_to;
    w_acepta       = 1'b0;
    w_expira       = 1'b0;
    if (!habilitar) begin
      w_seq_next     = ESPERA;
      w_cnt_per_next = '0;
      w_cnt_to_next  = '0;
    end else begin
      case (r_seq)
        ESPERA: begin
          if (r_cnt_per == PER_MAX) begin
            w_seq_next     = SOLICITA;
            w_cnt_per_next = '0;
            w_cnt_to_next  = '0;
          end else begin
            w_cnt_per_next = r_cnt_per + 1'b1;
          end
        end
        SOLICITA: begin
          // A valid reading on the expiry cycle still wins over the timeout.
          if (dato_valido && r_solicitud) begin
            w_acepta       = 1'b1;
            w_seq_next     = ESPERA;
            w_cnt_per_next = '0;
            w_cnt_to_next  = '0;
          end else if (r_cnt_to == TO_MAX) begin
            w_expira       = 1'b1;
            w_seq_next     = ESPERA;
            w_cnt_per_next = '0;
            w_cnt_to_next  = '0;
          end else begin
            w_cnt_to_next  = r_cnt_to + 1'b1;
          end
        end
        default: begin
          w_seq_next     = ESPERA;
          w_cnt_per_next = '0;
          w_cnt_to_next  = '0;
        end
      endcase
    end
  end

  logic signed [10:0] r_temp;
  logic               r_muestra;
  logic               r_error;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_temp    <= '0;
      r_muestra <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_muestra <= w_acepta;
      if (w_acepta) begin
        r_temp  <= temp_in;
        r_error <= 1'b0;
      end else if (w_expira) begin
        r_error <= 1'b1;
      end
    end
  end

  logic w_frio;
  logic w_fuera;

  assign w_frio  = (temp_in < TEMP_BAJO);
  assign w_fuera = w_frio || (temp_in > TEMP_ALTO);

  alm_t            r_alm, w_alm_next;
  logic [W_NA-1:0] r_cnt_fuera, w_cnt_fuera_next;
  logic [W_ND-1:0] r_cnt_dentro, w_cnt_dentro_next;
  logic            r_lado_frio, w_lado_frio_next;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_alm        <= NORMAL;
      r_cnt_fuera  <= '0;
      r_cnt_dentro <= '0;
      r_lado_frio  <= 1'b0;
    end else begin
      r_alm        <= w_alm_next;
      r_cnt_fuera  <= w_cnt_fuera_next;
      r_cnt_dentro <= w_cnt_dentro_next;
      r_lado_frio  <= w_lado_frio_next;
    end
  end

  always_comb begin
    w_alm_next        = r_alm;
    w_cnt_fuera_next  = r_cnt_fuera;
    w_cnt_dentro_next = r_cnt_dentro;
    w_lado_frio_next  = r_lado_frio;
    if (w_acepta) begin
      if (w_fuera) w_lado_frio_next = w_frio;
      case (r_alm)
        NORMAL: begin
          if (w_fuera) begin
            if (N_ACTIVAR == 1) begin
              w_alm_next       = ALARMA;
              w_cnt_fuera_next = '0;
            end else begin
              w_alm_next       = PRE_ALARMA;
              w_cnt_fuera_next = W_NA'(1);
            end
          end
        end
        PRE_ALARMA: begin
          if (!w_fuera) begin
            w_alm_next       = NORMAL;
            w_cnt_fuera_next = '0;
          end else if (r_cnt_fuera == NA_M1) begin
            w_alm_next       = ALARMA;
            w_cnt_fuera_next = '0;
          end else begin
            w_cnt_fuera_next = r_cnt_fuera + 1'b1;
          end
        end
        ALARMA: begin
          if (!w_fuera) begin
            if (N_DESACTIVAR == 1) begin
              w_alm_next        = NORMAL;
              w_cnt_dentro_next = '0;
            end else begin
              w_alm_next        = PRE_NORMAL;
              w_cnt_dentro_next = W_ND'(1);
            end
          end
        end
        PRE_NORMAL: begin
          if (w_fuera) begin
            w_alm_next        = ALARMA;
            w_cnt_dentro_next = '0;
          end else if (r_cnt_dentro == ND_M1) begin
            w_alm_next        = NORMAL;
            w_cnt_dentro_next = '0;
          end else begin
            w_cnt_dentro_next = r_cnt_dentro + 1'b1;
          end
        end
        default: begin
          w_alm_next        = NORMAL;
          w_cnt_fuera_next  = '0;
          w_cnt_dentro_next = '0;
        end
      endcase
    end
  end

  assign solicitud           = r_solicitud;
  assign temp_actual         = r_temp;
  assign muestra_nueva       = r_muestra;
  assign error_sensor        = r_error;
  assign alarma              = (r_alm == ALARMA) || (r_alm == PRE_NORMAL);
  assign alarma_frio         = alarma && r_lado_frio;
  assign alarma_calor        = alarma && !r_lado_frio;
  assign o_dbg_estado_seq    = r_seq;
  assign o_dbg_estado_alarma = r_alm;

endmodule

// File: doc/control_alarma_temp.md
Name: control_alarma_temp

Overview:
- Sequences periodic readings from the temperature sensor interface and runs a debounce/hysteresis state machine on the readings.
- Classifies each reading as in or out of range against the scaled limits: °C×10, signed 11-bit, where 180 = 18.0 °C.
- Produces debounced cold/heat alarm flags, the last valid temperature, and a sensor-timeout error.
- Sits between the sensor read path and the display/alarm outputs of the monitoring system.

Parameters:
- PERIODO, 1000: cycles spent in ESPERA between consecutive sensor requests (≥2).
- TIMEOUT, 64: cycles to wait for dato_valido after solicitud rises (≥1).
- TEMP_BAJO, 180: lower limit, scaled. A reading strictly below it is out of range.
- TEMP_ALTO, 259: upper limit, scaled. A reading strictly above it is out of range.
- N_ACTIVAR, 3: consecutive out-of-range readings needed to raise the alarm (≥1).
- N_DESACTIVAR, 2: consecutive in-range readings needed to clear the alarm (≥1).

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- habilitar, input, 1: enables sampling. When 0 the sequencer idles.
- temp_in, input, 11 signed: sensor reading, scaled °C×10.
- dato_valido, input, 1: temp_in is valid this cycle. Honoured only while solicitud=1.
- solicitud, output, 1: request to the sensor. Held high until answered or timed out.
- temp_actual, output, 11 signed: last accepted reading.
- muestra_nueva, output, 1: one-cycle pulse when temp_actual updates.
- alarma, output, 1: debounced out-of-range alarm.
- alarma_frio, output, 1: alarm caused by low temperature.
- alarma_calor, output, 1: alarm caused by high temperature.
- error_sensor, output, 1: sticky timeout flag.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; temp_actual = 0.
  - Sequencer in ESPERA with cnt_periodo = 0.
  - Alarm FSM in NORMAL with both run counters 0.
- Sequencer states:
  - ESPERA: cnt_periodo increments while habilitar=1. When it reaches PERIODO-1, go to SOLICITA; solicitud is registered high on the next cycle.
  - SOLICITA: solicitud=1 and cnt_timeout increments each cycle.
    - dato_valido=1: accept temp_in that cycle, drop solicitud next cycle, go to ESPERA with cnt_periodo = 0.
    - No dato_valido within TIMEOUT cycles: drop solicitud, set error_sensor=1, go to ESPERA. No reading is accepted and the alarm FSM is untouched.
  - Sampling interval is therefore PERIODO + response latency.
- dato_valido while solicitud=0 is ignored.
- dato_valido in the same cycle the timeout expires counts as accepted: valid wins and no error is raised.
- Accepted reading, effects on the following cycle:
  - temp_actual is registered and muestra_nueva pulses for exactly one cycle.
  - error_sensor clears.
  - The alarm FSM evaluates fuera = (temp < TEMP_BAJO) || (temp > TEMP_ALTO). Compare as signed; readings equal to a limit are in range.
- Alarm FSM (steps once per accepted reading only):
  - NORMAL: fuera → cnt_fuera = 1, then ALARMA if N_ACTIVAR=1, else PRE_ALARMA.
  - PRE_ALARMA:
    - fuera → cnt_fuera+1; on reaching N_ACTIVAR go to ALARMA.
    - in range → NORMAL with cnt_fuera = 0.
  - ALARMA:
    - in range → cnt_dentro = 1, then NORMAL if N_DESACTIVAR=1, else PRE_NORMAL.
    - fuera → stay.
  - PRE_NORMAL:
    - in range → cnt_dentro+1; on reaching N_DESACTIVAR go to NORMAL.
    - fuera → ALARMA with cnt_dentro = 0.
- Alarm outputs:
  - alarma = 1 in ALARMA and PRE_NORMAL.
  - alarma_frio / alarma_calor reflect the side of the most recent out-of-range reading and update on every out-of-range reading while alarma=1. Exactly one is high when alarma=1; both are 0 otherwise.
  - A direct swing from cold to hot inside the alarm flips the flags without dropping alarma.
- habilitar=0:
  - Sequencer forced to ESPERA next cycle, solicitud=0, cnt_periodo and cnt_timeout held at 0.
  - An in-flight request is abandoned with no error.
  - Alarm FSM state, flags and temp_actual are retained.
- Reset mid-request: solicitud drops immediately (async). After release, sampling restarts from cnt_periodo = 0.
- Counter width is $clog2 of the maximum count; counters saturate and never wrap.

Test Plan:
All cases use PERIODO=8, TIMEOUT=4, N_ACTIVAR=3, N_DESACTIVAR=2.
- Reset then habilitar=1 → solicitud rises 9 cycles after reset release. The sensor answers 2 cycles later with 220. → temp_actual=220, muestra_nueva pulses once, alarma=0, next request 8 cycles after acceptance.
- Readings 300, 300, 300 → alarma=1 and alarma_calor=1 on the cycle after the 3rd reading. Sequence 300, 300, 200 → alarma stays 0 and the FSM returns to NORMAL.
- From alarm: readings 150 (flags flip to frio=1, calor=0, alarma stays 1), then 200, 210 → alarma=0 after the 2nd in-range reading. Sequence 200, 170 → back to ALARMA with frio=1.
- Boundary readings 180, 259 → in range. Readings 179, 260 → out of range. Reading -5 → cold.
- No dato_valido for 4 cycles → solicitud drops, error_sensor=1, alarm state unchanged. The next valid reading clears error_sensor. dato_valido on the expiry cycle → accepted, no error.
- habilitar=0 mid-request → solicitud=0 next cycle, no error, alarma retained. Async rst_n pulse mid-request → all outputs 0 immediately.
